tx_packet_fetcher: RTL and testbench

TX_PACKET_FETCHER -- requirements
Module: tx_packet_fetcher

---
 rtl/tx_packet_fetcher_pkg.sv | 30 +++
 rtl/tx_packet_fetcher_skid_buffer.sv | 48 ++++
 rtl/tx_packet_fetcher.sv | 140 ++++++++++++++
 tb/tb_tx_packet_fetcher.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_packet_fetcher_pkg.sv
// Shared types and constants for the TX packet fetcher.
package tx_packet_fetcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam int         BYTES_PER_BEAT = 8;
  localparam int         BEAT_DATA_W    = 64;

  // One AXI-Stream beat as held in the output buffer (73 bits).
  typedef struct packed {
    logic [BEAT_DATA_W-1:0]    tdata;
    logic [BYTES_PER_BEAT-1:0] tkeep;
    logic                      tlast;
  } axis_beat_t;

  // Byte-enable mask for the final beat: low 'rem' bytes valid, all bytes when rem is 0.
  function automatic logic [7:0] last_keep(input logic [2:0] rem);
    logic [7:0] mask;
    mask = 8'hFF << rem;
    return (rem == 3'd0) ? 8'hFF : ~mask;
  endfunction

endpackage

// File: rtl/tx_packet_fetcher_skid_buffer.sv
// Two-entry output buffer: full rate when the sink is ready, output held stable while stalled.
module axis_skid_buffer #(
  parameter int WIDTH = 73
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic             push, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy gates its visibility.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/tx_packet_fetcher.sv
// Fetches one packet per descriptor with a single AXI4 INCR burst and streams it out on AXI-Stream.
module tx_packet_fetcher
  import tx_packet_fetcher_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH    = 32,
  parameter int PACKET_SIZE_WIDTH = 11,
  parameter int AXI_DATA_WIDTH    = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          valid_packet_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     addr_packet_i,
  input  logic [PACKET_SIZE_WIDTH-1:0]  length_packet_i,
  output logic                          ack_o,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int CNT_W = PACKET_SIZE_WIDTH + 1;

  state_e                         state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]      addr_q;
  logic [PACKET_SIZE_WIDTH-1:0]   len_q;
  logic [7:0]                     beat_cnt_q;
  logic                           err_q;
  logic [CNT_W-1:0]               beats;
  logic [7:0]                     arlen;
  logic                           is_last;
  logic                           r_hs;
  logic                           buf_in_ready, buf_out_valid;
  axis_beat_t                     beat_in, beat_out;

  // Beat count is kept one bit wider so a 2047-byte packet yields 256 beats.
  assign beats   = ({1'b0, len_q} + CNT_W'(BYTES_PER_BEAT - 1)) >> $clog2(BYTES_PER_BEAT);
  assign arlen   = 8'(beats - CNT_W'(1));
  assign is_last = (beat_cnt_q == arlen);
  assign r_hs    = (state_q == ST_DATA) && m_axi_rvalid && buf_in_ready;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen;
  assign m_axi_arsize  = AXI_SIZE_8B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign busy_o        = (state_q != ST_IDLE) || buf_out_valid;
  assign err_o         = err_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and handshake outputs; ack is masked during reset since it is combinational.
  always_comb begin
    state_d       = state_q;
    ack_o         = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_packet_i) begin
          ack_o = rst_n_i;
          if (length_packet_i != '0) state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        m_axi_rready = buf_in_ready;
        if (r_hs && is_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat counter and sticky error; tlast comes from the counter, rlast is only cross-checked.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      beat_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == ST_IDLE)  beat_cnt_q <= 8'd0;
      else if (r_hs)           beat_cnt_q <= is_last ? 8'd0 : beat_cnt_q + 8'd1;
      if (r_hs && ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != is_last)))
        err_q <= 1'b1;
    end
  end

  // Descriptor capture; held constant through ADDR and DATA.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_IDLE && valid_packet_i) begin
      addr_q <= addr_packet_i;
      len_q  <= length_packet_i;
    end
  end

  // Build the outgoing beat from the read data and the internal position.
  always_comb begin
    beat_in       = '0;
    beat_in.tdata = m_axi_rdata;
    beat_in.tkeep = is_last ? last_keep(len_q[2:0]) : 8'hFF;
    beat_in.tlast = is_last;
  end

  axis_skid_buffer #(
    .WIDTH($bits(axis_beat_t))
  ) u_out_buf (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .in_valid  (r_hs),
    .in_ready  (buf_in_ready),
    .in_data   (beat_in),
    .out_valid (buf_out_valid),
    .out_ready (m_axis_tready),
    .out_data  (beat_out)
  );

  assign m_axis_tvalid = buf_out_valid;
  assign m_axis_tdata  = beat_out.tdata;
  assign m_axis_tkeep  = beat_out.tkeep;
  assign m_axis_tlast  = beat_out.tlast;

endmodule

// File: tb/tb_tx_packet_fetcher.sv
// Directed bench: AXI read slave model, AXIS sink with capture, per-scenario checking tasks.
module tb_tx_packet_fetcher;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        valid_packet_i = 1'b0;
  logic [31:0] addr_packet_i = '0;
  logic [10:0] length_packet_i = '0;
  logic        ack_o;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [63:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        busy_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  tx_packet_fetcher dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .valid_packet_i(valid_packet_i), .addr_packet_i(addr_packet_i),
    .length_packet_i(length_packet_i), .ack_o(ack_o),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy_o(busy_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit stall = 1'b0;
  int err_beat = -1;

  logic [31:0] bq_addr[$];
  int          bq_n[$];
  bit          cur_act = 1'b0;
  logic [31:0] cur_addr = '0;
  int          cur_n = 0, cur_idx = 0;

  logic [63:0] cap_data[$];
  logic [7:0]  cap_keep[$];
  logic        cap_last[$];
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  int          burst_end_q[$];
  logic [2:0]  ar_size_l;
  logic [1:0]  ar_burst_l;
  int ack_cnt, arv_cnt, busy_cnt, first_r_cyc, first_t_cyc, err_hs_cyc, err_cyc, ack_cyc;

  // Payload the slave returns for beat i of a burst at address a.
  function automatic logic [63:0] pat(input logic [31:0] a, input int i);
    return {a + 32'(i * 8), 32'hBEEF0000 | 32'(i)};
  endfunction

  // Slave model, sink and monitor: drive at the falling edge, observe 1 ns later.
  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_n_i) begin
        cur_act = 1'b0;
        bq_addr.delete();
        bq_n.delete();
      end else if (!cur_act && bq_addr.size() > 0) begin
        cur_addr = bq_addr.pop_front();
        cur_n    = bq_n.pop_front();
        cur_idx  = 0;
        cur_act  = 1'b1;
      end
      m_axi_arready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      m_axi_rvalid  = cur_act && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
      m_axi_rdata   = pat(cur_addr, cur_idx);
      m_axi_rlast   = cur_act && (cur_idx == cur_n - 1);
      m_axi_rresp   = (cur_act && cur_idx == err_beat) ? 2'b10 : 2'b00;
      m_axis_tready = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
      #1;
      if (m_axi_arvalid && m_axi_arready) begin
        ar_addr_q.push_back(m_axi_araddr);
        ar_len_q.push_back(m_axi_arlen);
        ar_size_l  = m_axi_arsize;
        ar_burst_l = m_axi_arburst;
        bq_addr.push_back(m_axi_araddr);
        bq_n.push_back(int'(m_axi_arlen) + 1);
      end
      if (m_axi_rvalid && m_axi_rready) begin
        if (first_r_cyc < 0) first_r_cyc = cyc;
        if (m_axi_rresp != 2'b00 && err_hs_cyc < 0) err_hs_cyc = cyc;
        cur_idx++;
        if (cur_idx == cur_n) begin
          cur_act = 1'b0;
          burst_end_q.push_back(cyc);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cap_data.push_back(m_axis_tdata);
        cap_keep.push_back(m_axis_tkeep);
        cap_last.push_back(m_axis_tlast);
      end
      if (m_axis_tvalid && first_t_cyc < 0) first_t_cyc = cyc;
      if (ack_o) begin ack_cnt++; ack_cyc = cyc; end
      if (m_axi_arvalid) arv_cnt++;
      if (busy_o) busy_cnt++;
      if (err_o && err_cyc < 0) err_cyc = cyc;
    end
  end

  task automatic clear_stats();
    cap_data.delete(); cap_keep.delete(); cap_last.delete();
    ar_addr_q.delete(); ar_len_q.delete(); burst_end_q.delete();
    ack_cnt = 0; arv_cnt = 0; busy_cnt = 0;
    first_r_cyc = -1; first_t_cyc = -1; err_hs_cyc = -1; err_cyc = -1; ack_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // Present a descriptor until acked; ok reports whether the ack arrived in time.
  task automatic send_desc(input logic [31:0] a, input logic [10:0] l, output bit ok);
    @(negedge clk_i);
    valid_packet_i  = 1'b1;
    addr_packet_i   = a;
    length_packet_i = l;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      #2;
      if (ack_o) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    @(posedge clk_i);
    #1 valid_packet_i = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      #2;
      if (cap_data.size() >= n && !busy_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    valid_packet_i = 1'b1;
    length_packet_i = 11'd8;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #2;
    checks++; if (ack_o !== 1'b0)         begin errors++; $display("FAIL reset_ack: got %b want 0", ack_o); end
    checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", m_axi_arvalid); end
    checks++; if (m_axi_rready !== 1'b0)  begin errors++; $display("FAIL reset_rready: got %b want 0", m_axi_rready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (busy_o !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (err_o !== 1'b0)         begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    valid_packet_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_len64();
    bit ok;
    logic [7:0] ek;
    clear_stats();
    send_desc(32'h1000, 11'd64, ok);
    checks++; if (!ok) begin errors++; $display("FAIL len64_ack_timeout: got none want ack"); end
    wait_done(8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL len64_done_timeout: got %0d beats want 8", cap_data.size()); end
    checks++; if (ack_cnt != 1) begin errors++; $display("FAIL len64_ack_cnt: got %0d want 1", ack_cnt); end
    checks++; if (ar_len_q.size() != 1 || ar_len_q[0] !== 8'd7) begin errors++; $display("FAIL len64_arlen: got %0d bursts arlen %0d want 1 arlen 7", ar_len_q.size(), ar_len_q[0]); end
    checks++; if (ar_addr_q[0] !== 32'h1000) begin errors++; $display("FAIL len64_araddr: got %h want 00001000", ar_addr_q[0]); end
    checks++; if (ar_size_l !== 3'd3 || ar_burst_l !== 2'b01) begin errors++; $display("FAIL len64_size_burst: got %0d/%0d want 3/1", ar_size_l, ar_burst_l); end
    checks++; if (cap_data.size() != 8) begin errors++; $display("FAIL len64_beats: got %0d want 8", cap_data.size()); end
    checks++; if (first_t_cyc - first_r_cyc != 1) begin errors++; $display("FAIL len64_latency: got %0d want 1", first_t_cyc - first_r_cyc); end
    for (int i = 0; i < 8; i++) begin
      ek = 8'hFF;
      checks++;
      if (cap_data[i] !== pat(32'h1000, i) || cap_keep[i] !== ek || cap_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL len64_beat%0d: got %h/%h/%b want %h/%h/%b", i, cap_data[i], cap_keep[i], cap_last[i], pat(32'h1000, i), ek, (i == 7));
      end
    end
  endtask

  task automatic test_partial();
    logic [31:0] a [2] = '{32'h2000, 32'h2800};
    logic [10:0] l [2] = '{11'd61, 11'd1};
    int          nb [2] = '{8, 1};
    logic [7:0]  lk [2] = '{8'h1F, 8'h01};
    logic [7:0]  ek;
    bit ok;
    for (int t = 0; t < 2; t++) begin
      clear_stats();
      send_desc(a[t], l[t], ok);
      wait_done(nb[t], ok);
      checks++; if (!ok) begin errors++; $display("FAIL partial%0d_timeout: got %0d beats want %0d", t, cap_data.size(), nb[t]); end
      checks++; if (ar_len_q[0] !== 8'(nb[t] - 1)) begin errors++; $display("FAIL partial%0d_arlen: got %0d want %0d", t, ar_len_q[0], nb[t] - 1); end
      checks++; if (cap_data.size() != nb[t]) begin errors++; $display("FAIL partial%0d_beats: got %0d want %0d", t, cap_data.size(), nb[t]); end
      for (int i = 0; i < nb[t]; i++) begin
        ek = (i == nb[t] - 1) ? lk[t] : 8'hFF;
        checks++;
        if (cap_data[i] !== pat(a[t], i) || cap_keep[i] !== ek || cap_last[i] !== (i == nb[t] - 1)) begin
          errors++;
          $display("FAIL partial%0d_beat%0d: got %h/%h/%b want %h/%h/%b", t, i, cap_data[i], cap_keep[i], cap_last[i], pat(a[t], i), ek, (i == nb[t] - 1));
        end
      end
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_stats();
    send_desc(32'h3000, 11'd0, ok);
    repeat (10) @(negedge clk_i);
    #2;
    checks++; if (!ok || ack_cnt != 1) begin errors++; $display("FAIL zero_ack: got %0d acks want 1", ack_cnt); end
    checks++; if (arv_cnt != 0) begin errors++; $display("FAIL zero_arvalid: got %0d cycles want 0", arv_cnt); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL zero_busy: got %0d cycles want 0", busy_cnt); end
    checks++; if (cap_data.size() != 0) begin errors++; $display("FAIL zero_beats: got %0d want 0", cap_data.size()); end
  endtask

  task automatic test_long_stall();
    bit ok;
    int bad = 0;
    logic [7:0] ek;
    clear_stats();
    stall = 1'b1;
    send_desc(32'h4800, 11'd2047, ok);
    wait_done(256, ok);
    stall = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL long_timeout: got %0d beats want 256", cap_data.size()); end
    checks++; if (ar_len_q[0] !== 8'd255) begin errors++; $display("FAIL long_arlen: got %0d want 255", ar_len_q[0]); end
    checks++; if (cap_data.size() != 256) begin errors++; $display("FAIL long_beats: got %0d want 256", cap_data.size()); end
    for (int i = 0; i < 256; i++) begin
      ek = (i == 255) ? 8'h7F : 8'hFF;
      checks++;
      if (cap_data[i] !== pat(32'h4800, i) || cap_keep[i] !== ek || cap_last[i] !== (i == 255)) begin
        errors++;
        if (bad < 4) $display("FAIL long_beat%0d: got %h/%h/%b want %h/%h/%b", i, cap_data[i], cap_keep[i], cap_last[i], pat(32'h4800, i), ek, (i == 255));
        bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok_a, ok_b, ok;
    logic [31:0] ea;
    logic [7:0]  ek;
    int k;
    clear_stats();
    send_desc(32'h7000, 11'd24, ok_a);
    send_desc(32'h7800, 11'd13, ok_b);
    wait_done(5, ok);
    checks++; if (!(ok_a && ok_b && ok)) begin errors++; $display("FAIL b2b_timeout: got %b%b%b want 111", ok_a, ok_b, ok); end
    checks++; if (ack_cnt != 2) begin errors++; $display("FAIL b2b_ack_cnt: got %0d want 2", ack_cnt); end
    checks++; if (burst_end_q.size() < 1 || ack_cyc != burst_end_q[0] + 1) begin errors++; $display("FAIL b2b_ack_timing: got cycle %0d want %0d", ack_cyc, burst_end_q[0] + 1); end
    checks++; if (ar_len_q.size() != 2 || ar_len_q[0] !== 8'd2 || ar_len_q[1] !== 8'd1) begin errors++; $display("FAIL b2b_arlen: got %0d bursts %0d,%0d want 2 bursts 2,1", ar_len_q.size(), ar_len_q[0], ar_len_q[1]); end
    checks++; if (cap_data.size() != 5) begin errors++; $display("FAIL b2b_beats: got %0d want 5", cap_data.size()); end
    for (int i = 0; i < 5; i++) begin
      ea = (i < 3) ? 32'h7000 : 32'h7800;
      k  = (i < 3) ? i : i - 3;
      ek = (i == 4) ? 8'h1F : 8'hFF;
      checks++;
      if (cap_data[i] !== pat(ea, k) || cap_keep[i] !== ek || cap_last[i] !== (i == 2 || i == 4)) begin
        errors++;
        $display("FAIL b2b_beat%0d: got %h/%h/%b want %h/%h/%b", i, cap_data[i], cap_keep[i], cap_last[i], pat(ea, k), ek, (i == 2 || i == 4));
      end
    end
  endtask

  task automatic test_err();
    bit ok;
    clear_stats();
    err_beat = 2;
    send_desc(32'h6000, 11'd64, ok);
    wait_done(8, ok);
    err_beat = -1;
    checks++; if (!ok || cap_data.size() != 8) begin errors++; $display("FAIL err_beats: got %0d want 8", cap_data.size()); end
    checks++; if (err_hs_cyc < 0 || err_cyc != err_hs_cyc + 1) begin errors++; $display("FAIL err_timing: got cycle %0d want %0d", err_cyc, err_hs_cyc + 1); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_data[i] !== pat(32'h6000, i) || cap_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL err_beat%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], pat(32'h6000, i), (i == 7));
      end
    end
    clear_stats();
    send_desc(32'h6800, 11'd8, ok);
    wait_done(1, ok);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_o); end
    do_reset();
    @(negedge clk_i); #2;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", err_o); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    clear_stats();
    send_desc(32'h8000, 11'd256, ok);
    repeat (8) @(negedge clk_i);
    rst_n_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i); #2;
    checks++; if (m_axi_rready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axi_arvalid !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: got rready %b tvalid %b arvalid %b busy %b want 0000", m_axi_rready, m_axis_tvalid, m_axi_arvalid, busy_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    clear_stats();
    send_desc(32'h8800, 11'd8, ok);
    wait_done(1, ok);
    checks++; if (!ok || cap_data.size() != 1) begin errors++; $display("FAIL midrst_beats: got %0d want 1", cap_data.size()); end
    checks++; if (cap_data[0] !== pat(32'h8800, 0) || cap_keep[0] !== 8'hFF || cap_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_beat: got %h/%h/%b want %h/ff/1", cap_data[0], cap_keep[0], cap_last[0], pat(32'h8800, 0));
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_len64();
    test_partial();
    test_zero_len();
    test_long_stall();
    test_back_to_back();
    test_err();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
